// File: rtl/uart_tx_sched_if.sv
// Scheduler-facing bundle: two FWFT FIFO read ports, the uart_tx launch/done handshake and status.
// master = scheduler side (drives pops, launch, byte, grant, busy); slave = FIFOs + uart_tx side.
// Pure wiring, no state.
interface uart_tx_sched_if;
  // channel 0: RGMII receive bytes from the CDC FIFO
  logic       i_Ch0_Empty;
  logic [7:0] i_Ch0_Data;
  logic       o_Ch0_Pop;
  // channel 1: local status/debug bytes
  logic       i_Ch1_Empty;
  logic [7:0] i_Ch1_Data;
  logic       o_Ch1_Pop;
  // uart_tx serializer handshake
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  // status
  logic [1:0] o_Grant;
  logic       o_Busy;

  modport master (
    input  i_Ch0_Empty, i_Ch0_Data, i_Ch1_Empty, i_Ch1_Data, i_Tx_Active, i_Tx_Done,
    output o_Ch0_Pop, o_Ch1_Pop, o_Tx_DV, o_Tx_Byte, o_Grant, o_Busy
  );

  modport slave (
    output i_Ch0_Empty, i_Ch0_Data, i_Ch1_Empty, i_Ch1_Data, i_Tx_Active, i_Tx_Done,
    input  o_Ch0_Pop, o_Ch1_Pop, o_Tx_DV, o_Tx_Byte, o_Grant, o_Busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between two FIFO read ports, round-robin per burst of up to MAX_BURST bytes.
// Latency: non-empty seen in IDLE -> o_Tx_DV next cycle; i_Tx_Done -> next launch after GAP_CLKS+3 cycles.
// Backpressure: holds in IDLE while i_Tx_Active is high; pops the owner FIFO only on i_Tx_Done.
// Build option: define UART_TX_SCHED_CH1_EN to enable channel 1; otherwise channel 1 is ignored.
module uart_tx_sched #(
  parameter int MAX_BURST = 64,  // bytes per burst before forced re-arbitration, >= 1
  parameter int GAP_CLKS  = 0    // extra idle clocks after each byte, on top of the 1-cycle settle
) (
  input  logic            i_Clock,
  input  logic            i_Rst_L,
  uart_tx_sched_if.master bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [BW-1:0] MAX_BURST_C = BW'(MAX_BURST);
  localparam logic [GW-1:0] GAP_C       = GW'(GAP_CLKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // arbitrate or continue the burst
    ST_WAIT = 2'd1,  // byte in flight inside uart_tx
    ST_GAP  = 2'd2   // settle so registered rempty reflects the pop, plus optional gap
  } state_e;

  state_e          state_q, state_d;
  logic            tx_dv_q, tx_dv_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [1:0]      grant_q, grant_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            last_q, last_d;  // channel index that owned the most recently closed burst

  // requests as seen by the arbiter
  logic            ch0_req;
  logic            ch1_req;
  logic [7:0]      ch1_data;

  // arbitration results
  logic            owner_req;
  logic            burst_open;
  logic            cont_burst;
  logic            last_eff;
  logic            launch;
  logic            sel_ch1;
  logic            idle_go;
  logic            launch_go;
  logic [BW-1:0]   burst_base;

  // FSM outputs
  logic            done_in_wait;
  logic            busy;
  logic            ch0_pop;
  logic            ch1_pop;

  assign ch0_req = ~bus.i_Ch0_Empty;

`ifdef UART_TX_SCHED_CH1_EN
  assign ch1_req  = ~bus.i_Ch1_Empty;
  assign ch1_data = bus.i_Ch1_Data;
`else
  // Channel 1 is not arbitrated in this build; its inputs are deliberately left unused.
  logic unused_ch1;
  assign unused_ch1 = ^{bus.i_Ch1_Empty, bus.i_Ch1_Data};
  assign ch1_req    = 1'b0;
  assign ch1_data   = 8'h00;
`endif

  // Decide whether IDLE continues the open burst or picks a new owner (round-robin on ties).
  always_comb begin
    owner_req = 1'b0;
    if (grant_q[0]) owner_req = ch0_req;
    if (grant_q[1]) owner_req = ch1_req;

    burst_open = (burst_cnt_q != '0);
    cont_burst = burst_open && (burst_cnt_q < MAX_BURST_C) && owner_req;
    // A burst closing this cycle already counts as the latest owner for the tie-break.
    last_eff   = burst_open ? grant_q[1] : last_q;

    launch  = 1'b0;
    sel_ch1 = 1'b0;
    if (cont_burst) begin
      launch  = 1'b1;
      sel_ch1 = grant_q[1];
    end else if (ch0_req && ch1_req) begin
      launch  = 1'b1;
      sel_ch1 = ~last_eff;
    end else if (ch1_req) begin
      launch  = 1'b1;
      sel_ch1 = 1'b1;
    end else if (ch0_req) begin
      launch  = 1'b1;
      sel_ch1 = 1'b0;
    end

    // uart_tx still active (e.g. reset hit mid-byte) blocks any decision in IDLE.
    idle_go   = (state_q == ST_IDLE) && !bus.i_Tx_Active;
    launch_go = idle_go && launch;
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> WAIT on launch, WAIT -> GAP on done, GAP -> IDLE when the count expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch_go) state_d = ST_WAIT;
      ST_WAIT: if (bus.i_Tx_Done) state_d = ST_GAP;
      ST_GAP:  if (gap_cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and the combinational pop that coincides with i_Tx_Done.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    done_in_wait = (state_q == ST_WAIT) && bus.i_Tx_Done;
    ch0_pop      = done_in_wait && grant_q[0];
`ifdef UART_TX_SCHED_CH1_EN
    ch1_pop      = done_in_wait && grant_q[1];
`else
    ch1_pop      = 1'b0;
`endif
  end

  // Datapath: burst bookkeeping, launch byte/pulse, gap counter.
  always_comb begin
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    last_d      = last_q;
    burst_base  = burst_cnt_q;

    // Close the burst; a new owner may still be picked in this same cycle.
    if (idle_go && !cont_burst) begin
      burst_cnt_d = '0;
      grant_d     = 2'b00;
      burst_base  = '0;
      if (burst_open) last_d = grant_q[1];
    end

    if (launch_go) begin
      tx_dv_d     = 1'b1;
      tx_byte_d   = sel_ch1 ? ch1_data : bus.i_Ch0_Data;
      grant_d     = sel_ch1 ? 2'b10 : 2'b01;
      // saturating count, never wraps
      burst_cnt_d = (burst_base == MAX_BURST_C) ? burst_base : burst_base + BW'(1);
    end

    if (done_in_wait) begin
      gap_cnt_d = GAP_C;
    end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
      gap_cnt_d = gap_cnt_q - GW'(1);
    end
  end

  // Datapath registers; last resets to channel 1 so channel 0 wins the first tie.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= 8'h00;
      grant_q     <= 2'b00;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
      last_q      <= 1'b1;
    end else begin
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      last_q      <= last_d;
    end
  end

  assign bus.o_Tx_DV   = tx_dv_q;
  assign bus.o_Tx_Byte = tx_byte_q;
  assign bus.o_Grant   = grant_q;
  assign bus.o_Busy    = busy;
  assign bus.o_Ch0_Pop = ch0_pop;
  assign bus.o_Ch1_Pop = ch1_pop;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with MAX_BURST=4, GAP_CLKS=5.
// FIFO and uart_tx behaviour come from a small reference model driven on the clock.
// Each test task resets the DUT, drives a scenario and compares against hand-computed values.
module tb_uart_tx_sched;
`ifdef UART_TX_SCHED_CH1_EN
  localparam bit CH1_ON = 1'b1;
`else
  localparam bit CH1_ON = 1'b0;
`endif
  localparam int UCLK = 4;  // uart_tx model: done arrives UCLK cycles after the launch

  logic i_Clock = 1'b0;
  logic i_Rst_L;

  uart_tx_sched_if bus();

  uart_tx_sched #(.MAX_BURST(4), .GAP_CLKS(5)) dut (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  always #5 i_Clock = ~i_Clock;

  int checks;
  int errors;

  // model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         cyc;
  bit         auto_uart;
  bit         man_active;
  bit         man_done;
  int         ucnt;
  bit         pend0, pend1;
  bit         in_flight;
  logic [7:0] held_byte;
  // logs
  logic [7:0] l_byte[$];
  logic [1:0] l_grant[$];
  int         l_cyc[$];
  int         d_cyc[$];
  int         p0_cyc[$];
  int         p1_cyc[$];
  int         pop_bad;
  int         byte_unstable;

  // FIFO + uart_tx model: drive at posedge+1, sample pops at posedge+3.
  initial begin : model
    cyc = 0; ucnt = 0; pend0 = 0; pend1 = 0; in_flight = 0; held_byte = 8'h00;
    bus.i_Ch0_Empty = 1'b1; bus.i_Ch0_Data = 8'h00;
    bus.i_Ch1_Empty = 1'b1; bus.i_Ch1_Data = 8'h00;
    bus.i_Tx_Active = 1'b0; bus.i_Tx_Done = 1'b0;
    forever begin
      @(posedge i_Clock);
      #1;
      cyc++;
      if (!i_Rst_L) begin
        pend0 = 0; pend1 = 0; ucnt = 0; in_flight = 0;
      end
      if (pend0) begin
        if (q0.size() > 0) q0.delete(0);
        pend0 = 0;
      end
      if (pend1) begin
        if (q1.size() > 0) q1.delete(0);
        pend1 = 0;
      end
      if (bus.o_Tx_DV) begin
        l_byte.push_back(bus.o_Tx_Byte);
        l_grant.push_back(bus.o_Grant);
        l_cyc.push_back(cyc);
        held_byte = bus.o_Tx_Byte;
        in_flight = 1;
      end else if (in_flight && (bus.o_Tx_Byte !== held_byte)) begin
        byte_unstable++;
      end
      if (!auto_uart) begin
        ucnt = 0;
        bus.i_Tx_Active = man_active;
        bus.i_Tx_Done   = man_done;
      end else if (!i_Rst_L) begin
        bus.i_Tx_Active = 1'b0; bus.i_Tx_Done = 1'b0;
      end else if (bus.o_Tx_DV) begin
        ucnt = UCLK;
        bus.i_Tx_Active = 1'b1; bus.i_Tx_Done = 1'b0;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) begin
          bus.i_Tx_Active = 1'b0; bus.i_Tx_Done = 1'b1;
        end else begin
          bus.i_Tx_Active = 1'b1; bus.i_Tx_Done = 1'b0;
        end
      end else begin
        bus.i_Tx_Active = 1'b0; bus.i_Tx_Done = 1'b0;
      end
      bus.i_Ch0_Empty = (q0.size() == 0);
      bus.i_Ch0_Data  = (q0.size() > 0) ? q0[0] : 8'h00;
      bus.i_Ch1_Empty = (q1.size() == 0);
      bus.i_Ch1_Data  = (q1.size() > 0) ? q1[0] : 8'h00;
      #2;
      if (bus.i_Tx_Done) begin
        d_cyc.push_back(cyc);
        in_flight = 0;
      end
      if (bus.o_Ch0_Pop) begin
        pend0 = 1; p0_cyc.push_back(cyc);
        if (!bus.i_Tx_Done) pop_bad++;
      end
      if (bus.o_Ch1_Pop) begin
        pend1 = 1; p1_cyc.push_back(cyc);
        if (!bus.i_Tx_Done) pop_bad++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #2;
    end
  endtask

  task automatic do_reset();
    step(1);
    i_Rst_L = 1'b0;
    q0.delete(); q1.delete();
    l_byte.delete(); l_grant.delete(); l_cyc.delete();
    d_cyc.delete(); p0_cyc.delete(); p1_cyc.delete();
    pop_bad = 0; byte_unstable = 0;
    step(2);
    i_Rst_L = 1'b1;
    step(1);
  endtask

  // Wait until all queued traffic has drained and the DUT has sat idle a few cycles.
  task automatic wait_quiet(input int budget, output bit ok);
    int calm;
    calm = 0;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step(1);
      if (!bus.o_Busy && !bus.o_Tx_DV && (ucnt == 0) && (q0.size() == 0) &&
          (!CH1_ON || (q1.size() == 0)))
        calm++;
      else
        calm = 0;
      if (calm >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_launches(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (l_byte.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0;
    step(2);
    checks++; if (bus.o_Tx_DV !== 1'b0) begin errors++; $display("FAIL reset_tx_dv got %0b want 0", bus.o_Tx_DV); end
    checks++; if (bus.o_Tx_Byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %02h want 00", bus.o_Tx_Byte); end
    checks++; if (bus.o_Grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %02b want 00", bus.o_Grant); end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.o_Busy); end
    checks++; if ({bus.o_Ch0_Pop, bus.o_Ch1_Pop} !== 2'b00) begin errors++; $display("FAIL reset_pops got %02b want 00", {bus.o_Ch0_Pop, bus.o_Ch1_Pop}); end
    i_Rst_L = 1'b1;
    step(3);
    checks++; if ((l_byte.size() != 0) || (bus.o_Busy !== 1'b0)) begin errors++; $display("FAIL reset_idle_empty launches %0d busy %0b want 0 0", l_byte.size(), bus.o_Busy); end
  endtask

  task automatic test_single();
    int push_cyc;
    bit ok;
    do_reset();
    q0.push_back(8'h55);
    push_cyc = cyc;
    wait_quiet(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout drained %0b want 1", ok); end
    checks++; if (l_byte.size() != 1) begin errors++; $display("FAIL single_launches got %0d want 1", l_byte.size()); end
    if (l_byte.size() >= 1) begin
      checks++; if (l_byte[0] !== 8'h55) begin errors++; $display("FAIL single_byte got %02h want 55", l_byte[0]); end
      checks++; if (l_grant[0] !== 2'b01) begin errors++; $display("FAIL single_grant got %02b want 01", l_grant[0]); end
      checks++; if (l_cyc[0] != push_cyc + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", l_cyc[0], push_cyc + 2); end
    end
    checks++; if ((p0_cyc.size() != 1) || (p1_cyc.size() != 0)) begin errors++; $display("FAIL single_pops ch0 %0d ch1 %0d want 1 0", p0_cyc.size(), p1_cyc.size()); end
    if ((p0_cyc.size() == 1) && (d_cyc.size() >= 1)) begin
      checks++; if (p0_cyc[0] != d_cyc[0]) begin errors++; $display("FAIL single_pop_on_done pop %0d done %0d", p0_cyc[0], d_cyc[0]); end
    end
    checks++; if (bus.o_Grant !== 2'b00) begin errors++; $display("FAIL single_grant_idle got %02b want 00", bus.o_Grant); end
    checks++; if ((pop_bad != 0) || (byte_unstable != 0)) begin errors++; $display("FAIL single_protocol pop_bad %0d unstable %0d want 0 0", pop_bad, byte_unstable); end
  endtask

  task automatic test_gap();
    bit ok;
    logic [7:0] exp_b [3];
    exp_b = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int i = 0; i < 3; i++) q0.push_back(exp_b[i]);
    wait_quiet(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_timeout drained %0b want 1", ok); end
    checks++; if ((l_byte.size() != 3) || (d_cyc.size() != 3) || (p0_cyc.size() != 3)) begin
      errors++; $display("FAIL gap_counts launches %0d dones %0d pops %0d want 3 3 3", l_byte.size(), d_cyc.size(), p0_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (l_byte[i] !== exp_b[i]) begin errors++; $display("FAIL gap_byte%0d got %02h want %02h", i, l_byte[i], exp_b[i]); end
        checks++; if (p0_cyc[i] != d_cyc[i]) begin errors++; $display("FAIL gap_pop%0d pop %0d done %0d", i, p0_cyc[i], d_cyc[i]); end
      end
      for (int i = 0; i < 2; i++) begin
        checks++; if (l_cyc[i+1] - d_cyc[i] != 8) begin errors++; $display("FAIL gap_spacing%0d got %0d want 8", i, l_cyc[i+1] - d_cyc[i]); end
      end
    end
  endtask

`ifdef UART_TX_SCHED_CH1_EN
  task automatic test_round_robin();
    bit ok;
    logic [7:0] exp_b [20];
    logic [1:0] exp_g;
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
              8'h04, 8'h05, 8'h06, 8'h07, 8'h14, 8'h15, 8'h16, 8'h17,
              8'h08, 8'h09, 8'h18, 8'h19};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(8'(i));
      q1.push_back(8'(8'h10 + i));
    end
    wait_quiet(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout drained %0b want 1", ok); end
    checks++; if (l_byte.size() != 20) begin errors++; $display("FAIL rr_launches got %0d want 20", l_byte.size()); end
    for (int i = 0; (i < 20) && (i < l_byte.size()); i++) begin
      exp_g = (exp_b[i] >= 8'h10) ? 2'b10 : 2'b01;
      checks++; if ((l_byte[i] !== exp_b[i]) || (l_grant[i] !== exp_g)) begin
        errors++; $display("FAIL rr_order%0d got %02h/%02b want %02h/%02b", i, l_byte[i], l_grant[i], exp_b[i], exp_g);
      end
    end
    checks++; if ((p0_cyc.size() != 10) || (p1_cyc.size() != 10)) begin errors++; $display("FAIL rr_pops ch0 %0d ch1 %0d want 10 10", p0_cyc.size(), p1_cyc.size()); end
    checks++; if ((pop_bad != 0) || (byte_unstable != 0)) begin errors++; $display("FAIL rr_protocol pop_bad %0d unstable %0d want 0 0", pop_bad, byte_unstable); end
  endtask

  task automatic test_owner_empty();
    bit ok;
    do_reset();
    q0.push_back(8'h01); q0.push_back(8'h02);
    q1.push_back(8'hA0);
    wait_quiet(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL oe_timeout drained %0b want 1", ok); end
    checks++; if ((l_byte.size() != 3) || (d_cyc.size() != 3)) begin
      errors++; $display("FAIL oe_counts launches %0d dones %0d want 3 3", l_byte.size(), d_cyc.size());
    end else begin
      checks++; if ({l_byte[0], l_byte[1], l_byte[2]} !== {8'h01, 8'h02, 8'hA0}) begin
        errors++; $display("FAIL oe_order got %02h %02h %02h want 01 02 a0", l_byte[0], l_byte[1], l_byte[2]);
      end
      checks++; if ({l_grant[0], l_grant[1], l_grant[2]} !== 6'b01_01_10) begin
        errors++; $display("FAIL oe_grants got %02b %02b %02b want 01 01 10", l_grant[0], l_grant[1], l_grant[2]);
      end
      checks++; if (l_cyc[2] - d_cyc[1] != 8) begin errors++; $display("FAIL oe_switch_spacing got %0d want 8", l_cyc[2] - d_cyc[1]); end
    end
    checks++; if ((p0_cyc.size() != 2) || (p1_cyc.size() != 1)) begin errors++; $display("FAIL oe_pops ch0 %0d ch1 %0d want 2 1", p0_cyc.size(), p1_cyc.size()); end
  endtask
`else
  task automatic test_ch1_ignored();
    bit ok;
    do_reset();
    q1.push_back(8'h77);
    for (int i = 1; i <= 6; i++) q0.push_back(8'(i));
    wait_quiet(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_timeout drained %0b want 1", ok); end
    checks++; if ((l_byte.size() != 6) || (d_cyc.size() != 6)) begin
      errors++; $display("FAIL ign_counts launches %0d dones %0d want 6 6", l_byte.size(), d_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if ((l_byte[i] !== 8'(i + 1)) || (l_grant[i] !== 2'b01)) begin
          errors++; $display("FAIL ign_byte%0d got %02h/%02b want %02h/01", i, l_byte[i], l_grant[i], 8'(i + 1));
        end
      end
      checks++; if (l_cyc[4] - d_cyc[3] != 8) begin errors++; $display("FAIL ign_regrant_spacing got %0d want 8", l_cyc[4] - d_cyc[3]); end
    end
    checks++; if ((p1_cyc.size() != 0) || (q1.size() != 1) || (p0_cyc.size() != 6)) begin
      errors++; $display("FAIL ign_pops ch1 %0d q1 %0d ch0 %0d want 0 1 6", p1_cyc.size(), q1.size(), p0_cyc.size());
    end
  endtask
`endif

  task automatic test_stray_done();
    auto_uart = 1'b0;
    man_active = 1'b0; man_done = 1'b0;
    do_reset();
    man_done = 1'b1;
    step(1);
    man_done = 1'b0;
    step(3);
    checks++; if (d_cyc.size() != 1) begin errors++; $display("FAIL stray_stimulus dones %0d want 1", d_cyc.size()); end
    checks++; if ((p0_cyc.size() != 0) || (p1_cyc.size() != 0) || (l_byte.size() != 0)) begin
      errors++; $display("FAIL stray_effect pops %0d %0d launches %0d want 0 0 0", p0_cyc.size(), p1_cyc.size(), l_byte.size());
    end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL stray_busy got %0b want 0", bus.o_Busy); end
    auto_uart = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    auto_uart = 1'b0;
    man_active = 1'b0; man_done = 1'b0;
    do_reset();
    q0.push_back(8'h3C);
    wait_launches(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_first_launch seen %0b want 1", ok); end
    man_active = 1'b1;
    step(3);
    checks++; if (bus.o_Busy !== 1'b1) begin errors++; $display("FAIL rst_in_wait busy %0b want 1", bus.o_Busy); end
    i_Rst_L = 1'b0;
    #1;
    checks++; if ({bus.o_Tx_DV, bus.o_Grant, bus.o_Busy, bus.o_Ch0_Pop} !== 5'b0) begin
      errors++; $display("FAIL rst_async dv %0b grant %02b busy %0b pop %0b want all 0", bus.o_Tx_DV, bus.o_Grant, bus.o_Busy, bus.o_Ch0_Pop);
    end
    step(2);
    i_Rst_L = 1'b1;
    step(6);
    checks++; if ((l_byte.size() != 1) || (p0_cyc.size() != 0) || (q0.size() != 1)) begin
      errors++; $display("FAIL rst_blocked launches %0d pops %0d q0 %0d want 1 0 1", l_byte.size(), p0_cyc.size(), q0.size());
    end
    man_active = 1'b0;
    wait_launches(2, 20, ok);
    checks++; if (!ok || (l_byte[1] !== 8'h3C) || (l_grant[1] !== 2'b01)) begin
      errors++; $display("FAIL rst_resend seen %0b byte %02h want 1 3c", ok, ok ? l_byte[1] : 8'h00);
    end
    man_active = 1'b1;
    step(3);
    man_done = 1'b1; man_active = 1'b0;
    step(1);
    man_done = 1'b0;
    wait_quiet(100, ok);
    checks++; if (!ok || (p0_cyc.size() != 1) || (l_byte.size() != 2) || (pop_bad != 0)) begin
      errors++; $display("FAIL rst_final drained %0b pops %0d launches %0d pop_bad %0d want 1 1 2 0", ok, p0_cyc.size(), l_byte.size(), pop_bad);
    end
    auto_uart = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    auto_uart = 1'b1; man_active = 1'b0; man_done = 1'b0;
    pop_bad = 0; byte_unstable = 0;
    i_Rst_L = 1'b0;
    test_reset();
    test_single();
    test_gap();
`ifdef UART_TX_SCHED_CH1_EN
    test_round_robin();
    test_owner_empty();
`else
    test_ch1_ignored();
`endif
    test_stray_done();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Byte scheduler that shares the single `uart_tx` serializer between two FIFO read ports. Channel 0 carries RGMII receive bytes from the CDC FIFO; channel 1 carries locally generated status/debug bytes. It arbitrates round-robin at burst granularity and issues one-cycle `i_Tx_DV` launches. It pops the granted FIFO only on `i_Tx_Done`. It sits in the 48 MHz domain between the FIFO read sides and `uart_tx`, and replaces the ad-hoc IDLE/START/XFER sequencer.

## Interface
- `MAX_BURST`, 64: bytes sent from one channel before forced re-arbitration (≥1).
- `GAP_CLKS`, 0: extra idle clocks inserted after each byte, on top of the fixed 1-cycle settle.
- `i_Clock` in 1: system clock (48 MHz).
- `i_Rst_L` in 1: reset, asynchronous assert, active-low.
- `i_Ch0_Empty` in 1: channel 0 FIFO empty (registered `rempty`).
- `i_Ch0_Data` in 8: channel 0 head byte, first-word fall-through.
- `o_Ch0_Pop` out 1: channel 0 `rinc`.
- `i_Ch1_Empty` in 1: channel 1 FIFO empty.
- `i_Ch1_Data` in 8: channel 1 head byte.
- `o_Ch1_Pop` out 1: channel 1 `rinc`.
- `o_Tx_DV` out 1: launch pulse to `uart_tx`.
- `o_Tx_Byte` out 8: byte to `uart_tx`, held stable from launch until done.
- `i_Tx_Active` in 1: `uart_tx` busy.
- `i_Tx_Done` in 1: `uart_tx` one-cycle done.
- `o_Grant` out 2: one-hot current owner; 00 when idle.
- `o_Busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: arbitrate, or continue the current burst.
  - WAIT: byte in flight.
  - GAP: settle/gap count.
- IDLE, with `i_Tx_Active`=0:
  - Continue condition: burst open (`burst_cnt`>0), `burst_cnt`<MAX_BURST, and the owner is non-empty. If it holds, relaunch the owner.
  - Otherwise close the burst: `burst_cnt`←0, `o_Grant`←00.
  - Then pick a requester. If only one is non-empty, grant it. If both are, grant the channel ≠ `last`. `last` resets to 1, so ch0 wins the first tie.
  - On a launch: `o_Tx_Byte`←selected data, `o_Tx_DV`←1 for exactly one cycle, `o_Grant` set, `burst_cnt`++, go to WAIT.
- WAIT:
  - On `i_Tx_Done`, the pop of the granted channel is combinational (`o_ChN_Pop` = WAIT & `i_Tx_Done` & grant[N]), held for that single cycle.
  - Go to GAP, load `gap_cnt`←GAP_CLKS.
  - `last`←current owner at burst close.
- GAP:
  - Dwell GAP_CLKS+1 cycles. The minimum of 1 lets registered `rempty` reflect the pop.
  - Then return to IDLE.
- `burst_cnt` width is clog2(MAX_BURST+1); it saturates and never wraps.
- Boundary conditions:
  - Owner goes empty mid-burst: burst closes and the other channel is granted with no idle cycle beyond IDLE's one.
  - Both empty: stay IDLE; `o_Tx_DV`=0, pops=0.
  - `i_Tx_Done` outside WAIT is ignored, with no pop.
  - `i_Tx_Active` high in IDLE (e.g. after reset mid-byte) blocks launch until low.
  - Reset during WAIT: the in-flight byte is not popped and is resent after reset. Duplicate-on-reset is the accepted behaviour.
- Reset values: state IDLE, `o_Tx_DV` 0, `o_Tx_Byte` 00, `o_Grant` 00, `o_Busy` 0, pops 0, `burst_cnt` 0, `gap_cnt` 0, `last` 1.

## Timing
- Non-empty seen in IDLE at cycle N → `o_Tx_DV` high in cycle N+1 only, `o_Tx_Byte` valid from N+1.
- `i_Tx_Done` at cycle D → pop in cycle D; GAP from D+1 to D+1+GAP_CLKS; IDLE at D+2+GAP_CLKS.
- Back-to-back launch spacing: `i_Tx_Done` to next `o_Tx_DV` = GAP_CLKS+3 cycles.
- Everything is synchronous to `i_Clock` except reset assertion.

## Configuration
- `UART_TX_SCHED_CH1_EN` defined: two-channel round-robin as above.
- Undefined:
  - Channel 1 is ignored (`i_Ch1_*` unused, `o_Ch1_Pop` tied 0).
  - Grant is only ever 00 or 01.
  - MAX_BURST still closes bursts, but ch0 is regranted on the very next IDLE cycle.

## Test plan
- Reset, ch0 holds 0x55, ch1 empty → one `o_Tx_DV` with `o_Tx_Byte`=0x55, one `o_Ch0_Pop` coincident with `i_Tx_Done`, then IDLE, `o_Grant`=00.
- MAX_BURST=4, both FIFOs preloaded with 10 bytes (ch0 0x00–0x09, ch1 0x10–0x19) → serial order 00–03, 10–13, 04–07, 14–17, 08,09, 18,19.
- GAP_CLKS=5, ch0 with 3 bytes → `i_Tx_Done`-to-next-`o_Tx_DV` spacing exactly 8 cycles.
- Ch0 goes empty after 2 of MAX_BURST=64 while ch1 holds 0xA0 → ch1 granted in the next IDLE, 0xA0 sent, no ch0 pop.
- Reset asserted mid-WAIT on byte 0x3C with `i_Tx_Active` high → no pop, no launch until `i_Tx_Active` falls, then 0x3C resent once.
- `UART_TX_SCHED_CH1_EN` undefined, ch1 non-empty with 0x77 → never sent, `o_Ch1_Pop` stays 0, ch0 traffic unaffected.
